// File: rtl/ofmap_write_arbiter.sv
// ofmap_write_arbiter: shares the ofmap buffer write port among NUM_REQ producers for one fill pass.
// Build option: OFMAP_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
`default_nettype none

module ofmap_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10
) (
  input  logic                      w_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         ofmap_size,
  input  logic                      buf_full,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   size_q, size_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [NUM_REQ-1:0]  grant;
  logic [DATA_W-1:0]   grant_data;
  logic                xfer;
  int                  idx;

`ifndef OFMAP_ARB_FIXED_PRIO_EN
  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic [RR_W-1:0]     grant_idx;
`endif

  // Grant search: first valid requester starting at the search origin, at most one winner.
  always_comb begin
    grant      = '0;
    grant_data = '0;
    xfer       = 1'b0;
    idx        = 0;
`ifndef OFMAP_ARB_FIXED_PRIO_EN
    grant_idx  = '0;
`endif
    if (state_q == S_FILL && !buf_full) begin
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef OFMAP_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = int'(rr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
        if (!xfer && req_valid[idx]) begin
          xfer       = 1'b1;
          grant[idx] = 1'b1;
          grant_data = req_data[idx*DATA_W +: DATA_W];
`ifndef OFMAP_ARB_FIXED_PRIO_EN
          grant_idx  = RR_W'(idx);
`endif
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    size_d    = size_q;
    count_d   = count_q;
    wr_en_d   = xfer;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifndef OFMAP_ARB_FIXED_PRIO_EN
    rr_d      = rr_q;
`endif
    if (xfer) begin
      wr_addr_d = base_q + count_q;
      wr_data_d = grant_data;
      count_d   = count_q + ADDR_W'(1);
`ifndef OFMAP_ARB_FIXED_PRIO_EN
      rr_d      = (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + RR_W'(1);
`endif
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          size_d  = ofmap_size;
          count_d = '0;
          state_d = (ofmap_size == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (xfer && (count_q == size_q - ADDR_W'(1))) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      size_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifndef OFMAP_ARB_FIXED_PRIO_EN
      rr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      size_q    <= size_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifndef OFMAP_ARB_FIXED_PRIO_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign req_ready = grant;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q == S_FILL);
  assign done      = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ofmap_write_arbiter.sv
// tb_ofmap_write_arbiter: directed fill passes with a write scoreboard for ofmap_write_arbiter.
// Expectations follow OFMAP_ARB_FIXED_PRIO_EN when defined.
`default_nettype none

module tb_ofmap_write_arbiter;

  logic        w_clk = 1'b0;
  logic        reset, start, buf_full;
  logic [9:0]  base_addr, ofmap_size;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        wr_en, busy, done;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [9:0]  q_addr[$];
  logic [15:0] q_data[$];
  logic [7:0]  cnt[4]     = '{default: 8'd0};
  logic [7:0]  exp_cnt[4] = '{default: 8'd0};
  logic [3:0]  hs;

  always #5 w_clk = ~w_clk;

  ofmap_write_arbiter #(.NUM_REQ(4), .DATA_W(16), .ADDR_W(10)) dut (
    .w_clk(w_clk), .reset(reset), .start(start), .base_addr(base_addr),
    .ofmap_size(ofmap_size), .buf_full(buf_full), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  // Each producer presents {id, 0, sequence number} and advances after each accepted word.
  always_comb begin
    req_data = '0;
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = {4'(i), 4'h0, cnt[i]};
  end

  initial begin
    forever begin
      @(negedge w_clk);
      hs = req_valid & req_ready & {4{~reset}};
      @(posedge w_clk);
      #1;
      for (int i = 0; i < 4; i++) if (hs[i] === 1'b1) cnt[i] = cnt[i] + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic push(input logic [9:0] a, input int r);
    q_addr.push_back(a);
    q_data.push_back({4'(r), 4'h0, exp_cnt[r]});
    exp_cnt[r] = exp_cnt[r] + 8'd1;
  endtask

  task automatic pulse_start(input logic [9:0] b, input logic [9:0] s);
    base_addr  = b;
    ofmap_size = s;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int exp_n, input string tag);
    int n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (done === 1'b1) break;
    end
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_last_wr_with_done"}, {31'd0, wr_en}, 32'd1);
  endtask

  // Scoreboard: every write must match the oldest expected entry.
  always @(negedge w_clk) begin
    if (wr_en === 1'b1) begin
      if (q_addr.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected none", wr_addr, wr_data);
      end else begin
        chk("wr_addr", {22'd0, wr_addr}, {22'd0, q_addr.pop_front()});
        chk("wr_data", {16'd0, wr_data}, {16'd0, q_data.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; buf_full = 1'b0;
    base_addr = '0; ofmap_size = '0; req_valid = 4'hF;
    repeat (3) tick();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {22'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_req_ready", {28'd0, req_ready}, 32'd0);

    // Basic fill from requester 2
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) push(10'h010 + 10'(k), 2);
    pulse_start(10'h010, 10'd4);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    wait_done(4, "basic");
    tick();
    chk("basic_busy_after", {31'd0, busy}, 32'd0);
    chk("basic_done_after", {31'd0, done}, 32'd0);
    chk("basic_wr_en_after", {31'd0, wr_en}, 32'd0);
    chk("basic_q_empty", q_addr.size(), 32'd0);

    // Arbitration with all requesters valid, pointer cleared by reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'hF;
`ifdef OFMAP_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 8; k++) push(10'h040 + 10'(k), 0);
`else
    for (int k = 0; k < 8; k++) push(10'h040 + 10'(k), k % 4);
`endif
    pulse_start(10'h040, 10'd8);
    wait_done(8, "arb");
    tick();
    chk("arb_q_empty", q_addr.size(), 32'd0);

    // Backpressure on pass cycles 3-5
    req_valid = 4'b0010;
    for (int k = 0; k < 6; k++) push(10'h080 + 10'(k), 1);
    pulse_start(10'h080, 10'd6);
    tick();
    tick();
    buf_full = 1'b1;
    #1;
    chk("bp_ready_c3", {28'd0, req_ready}, 32'd0);
    chk("bp_inflight_wr", {31'd0, wr_en}, 32'd1);
    tick();
    chk("bp_ready_c4", {28'd0, req_ready}, 32'd0);
    chk("bp_wr_en_c4", {31'd0, wr_en}, 32'd0);
    tick();
    chk("bp_ready_c5", {28'd0, req_ready}, 32'd0);
    chk("bp_wr_en_c5", {31'd0, wr_en}, 32'd0);
    tick();
    buf_full = 1'b0;
    wait_done(4, "bp");
    tick();
    chk("bp_q_empty", q_addr.size(), 32'd0);

    // Zero-size pass
    req_valid = 4'b0001;
    pulse_start(10'h123, 10'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    chk("zero_done_end", {31'd0, done}, 32'd0);
    chk("zero_busy_end", {31'd0, busy}, 32'd0);

    // Address wrap past all-ones
    req_valid = 4'b1000;
    push(10'h3FE, 3); push(10'h3FF, 3); push(10'h000, 3); push(10'h001, 3);
    pulse_start(10'h3FE, 10'd4);
    wait_done(4, "wrap");
    tick();
    chk("wrap_q_empty", q_addr.size(), 32'd0);

    // Reset after five transfers of a ten-word pass
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) push(10'h200 + 10'(k), 0);
    pulse_start(10'h200, 10'd10);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {28'd0, req_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("abort_no_done", {31'd0, done}, 32'd0);
    chk("abort_no_wr", {31'd0, wr_en}, 32'd0);
    chk("abort_q_empty", q_addr.size(), 32'd0);
    push(10'h100, 0); push(10'h101, 0);
    pulse_start(10'h100, 10'd2);
    wait_done(2, "restart");
    tick();
    chk("restart_q_empty", q_addr.size(), 32'd0);

    // Start pulses during FILL and DONE are ignored
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) push(10'h300 + 10'(k), 2);
    pulse_start(10'h300, 10'd5);
    tick();
    base_addr = 10'h000; ofmap_size = 10'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3, "ign");
    ofmap_size = 10'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", {31'd0, busy}, 32'd0);
    chk("ign_done", {31'd0, done}, 32'd0);
    tick();
    chk("ign_busy2", {31'd0, busy}, 32'd0);
    chk("ign_wr_en", {31'd0, wr_en}, 32'd0);
    chk("ign_q_empty", q_addr.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ofmap_write_arbiter.md
Name: ofmap_write_arbiter

Overview:
- Shares the single output-feature-map buffer write port between NUM_REQ result producers (systolic-array columns / PE rows).
- Sequences one fill pass: takes a start pulse, a base address and a word count, then grants requesters and issues exactly ofmap_size buffer writes at consecutive addresses.
- Signals done once the pass completes.
- Sits between the PE array outputs and the output buffer; replaces ad-hoc per-producer enable logic.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_W, 16, width of one output word
- ADDR_W, 10, buffer address width; also the width of the word count

Ports:
- w_clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle pulse; begins a fill pass (honoured only in IDLE)
- base_addr  input  ADDR_W  first buffer address, sampled on accepted start
- ofmap_size  input  ADDR_W  number of words to write, sampled on accepted start
- buf_full  input  1  buffer backpressure; no grant issued while high
- req_valid  input  NUM_REQ  per-requester word available
- req_data  input  NUM_REQ*DATA_W  packed words, requester i at bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant, combinational from state/req_valid/buf_full/pointer
- wr_en  output  1  buffer write strobe (registered)
- wr_addr  output  ADDR_W  buffer write address (registered)
- wr_data  output  DATA_W  buffer write data (registered)
- busy  output  1  high in FILL
- done  output  1  one-cycle pulse at end of pass

Behaviour:
- Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, count=0, rr pointer=0. req_ready is 0 while in reset state.
- Reset asserted mid-pass: aborts immediately. The next cycle is IDLE with all outputs at reset values. No done pulse is generated.
- States: IDLE, FILL, DONE.
  - IDLE -> FILL on start when ofmap_size != 0. base_addr and ofmap_size are latched, count is cleared.
  - IDLE -> DONE on start when ofmap_size == 0. No writes occur.
  - FILL -> DONE in the cycle the transfer with count == size-1 occurs.
  - DONE -> IDLE unconditionally. done=1 only while in DONE.
  - start outside IDLE is ignored.
- Grant rules: req_ready is all-zero unless state==FILL and buf_full==0.
  - Otherwise exactly one bit is set: the first valid requester at or after rr_ptr, searching with wrap modulo NUM_REQ.
  - No valid requester -> req_ready is 0.
  - A transfer occurs when req_valid[i] & req_ready[i]. A requester must hold valid and data until granted.
- On transfer: rr_ptr <= (granted index + 1) mod NUM_REQ, count <= count+1.
- Write latency is 1 cycle: in the following cycle wr_en=1, wr_data = granted word, wr_addr = base + count_at_transfer. Otherwise wr_en=0; wr_addr and wr_data hold their last values.
- Address arithmetic is ADDR_W bits, modulo 2^ADDR_W: base+count wraps past all-ones to 0 silently.
- ofmap_size is treated as unsigned. All-ones gives 2^ADDR_W-1 writes.
- buf_full rises mid-pass: grants stop the same cycle. A write already registered still completes.
- busy=1 exactly in FILL. The final wr_en occurs in the same cycle as done=1.
- At most one write per cycle; throughput is 1 word/cycle when any requester is valid and buf_full=0.

Optional Feature:
- Macro OFMAP_ARB_FIXED_PRIO_EN.
- When defined: the grant goes to the lowest-index valid requester; rr_ptr is not implemented and is absent from logic.
- When undefined (default): round-robin as in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Basic fill: base=0x010, size=4, only req 2 valid continuously, start pulse -> wr_en high 4 consecutive cycles with addresses 0x010..0x013 and req 2 data in order; done pulse coincides with the 4th wr_en; busy low afterwards.
- Round-robin: size=8, all 4 requesters valid -> grant order 0,1,2,3,0,1,2,3; each requester's data is written to addresses base+0..7 respectively.
  - With OFMAP_ARB_FIXED_PRIO_EN: all 8 grants go to req 0.
- Backpressure: size=6, buf_full high cycles 3-5 of the pass -> req_ready=0 and no new wr_en beyond the in-flight one; exactly 6 writes total; done follows the 6th write.
- Boundaries:
  - start with size=0 -> no wr_en, busy stays 0, done pulses 1 cycle after start.
  - base=0x3FE, size=4 (ADDR_W=10) -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-pass: size=10, reset asserted after 5 transfers -> next cycle wr_en=0, busy=0, no done. A new start with base=0x100, size=2 then writes 0x100 and 0x101.
- Start ignored: second start pulse during FILL and during DONE -> no change in count or addresses; pass completes with the original size.
